// File: rtl/draw_arbiter.sv
// draw_arbiter: round-robin owner of the single sprite drawer.
// Three requesters (0 char FSM, 1 platform, 2 button) are served one at a
// time. The winner's command is latched, the drawer gets a start pulse, and
// the grant is released on the drawer's done pulse or on watchdog expiry.
module draw_arbiter #(
    parameter int TIMEOUT = 4095
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [2:0]  req,
    input  logic [2:0]  kind,
    input  logic [26:0] x_in,
    input  logic [23:0] y_in,
    output logic [2:0]  grant,
    output logic [2:0]  done,
    output logic        drawStart,
    output logic        drawKind,
    output logic [8:0]  drawX,
    output logic [7:0]  drawY,
    input  logic        drawDone,
    output logic        timeout,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Counter value on the last WAIT cycle before the watchdog fires.
    localparam logic [11:0] CNT_LAST = 12'(TIMEOUT - 1);

    state_t      state_r;
    logic [1:0]  last_r;
    logic [1:0]  idx_r;
    logic [11:0] cnt_r;
    logic [2:0]  grant_r;
    logic [2:0]  done_r;
    logic        start_r;
    logic        kind_r;
    logic [8:0]  x_r;
    logic [7:0]  y_r;
    logic        timeout_r;
    logic        busy_r;

    logic [1:0]  pick_s;
    logic        sel_kind_s;
    logic [8:0]  sel_x_s;
    logic [7:0]  sel_y_s;

    // Round-robin search starting one past the most recently released index.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] res;
        case (last)
            2'd0: begin
                if (r[1])      res = 2'd1;
                else if (r[2]) res = 2'd2;
                else           res = 2'd0;
            end
            2'd1: begin
                if (r[2])      res = 2'd2;
                else if (r[0]) res = 2'd0;
                else           res = 2'd1;
            end
            default: begin
                if (r[0])      res = 2'd0;
                else if (r[1]) res = 2'd1;
                else           res = 2'd2;
            end
        endcase
        return res;
    endfunction

    // One-hot grant vector for a requester index.
    function automatic logic [2:0] onehot(input logic [1:0] idx);
        logic [2:0] res;
        case (idx)
            2'd0:    res = 3'b001;
            2'd1:    res = 3'b010;
            2'd2:    res = 3'b100;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    // Winner of the round-robin search and its command fields.
    always_comb begin
        pick_s     = rr_pick(req, last_r);
        sel_kind_s = 1'b0;
        sel_x_s    = 9'd0;
        sel_y_s    = 8'd0;
        case (pick_s)
            2'd0: begin
                sel_kind_s = kind[0];
                sel_x_s    = x_in[8:0];
                sel_y_s    = y_in[7:0];
            end
            2'd1: begin
                sel_kind_s = kind[1];
                sel_x_s    = x_in[17:9];
                sel_y_s    = y_in[15:8];
            end
            2'd2: begin
                sel_kind_s = kind[2];
                sel_x_s    = x_in[26:18];
                sel_y_s    = y_in[23:16];
            end
            default: begin
                sel_kind_s = 1'b0;
                sel_x_s    = 9'd0;
                sel_y_s    = 8'd0;
            end
        endcase
    end

    // Arbitration FSM with all outputs registered on the state transitions.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r   <= IDLE;
            last_r    <= 2'd2;
            idx_r     <= 2'd0;
            cnt_r     <= 12'd0;
            grant_r   <= 3'b000;
            done_r    <= 3'b000;
            start_r   <= 1'b0;
            kind_r    <= 1'b0;
            x_r       <= 9'd0;
            y_r       <= 8'd0;
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req != 3'b000) begin
                        idx_r   <= pick_s;
                        grant_r <= onehot(pick_s);
                        kind_r  <= sel_kind_s;
                        x_r     <= sel_x_s;
                        y_r     <= sel_y_s;
                        start_r <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    start_r <= 1'b0;
                    cnt_r   <= 12'd0;
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (drawDone) begin
                        done_r    <= grant_r;
                        timeout_r <= 1'b0;
                        state_r   <= RELEASE;
                    end else if (cnt_r == CNT_LAST) begin
                        done_r    <= grant_r;
                        timeout_r <= 1'b1;
                        state_r   <= RELEASE;
                    end else begin
                        cnt_r <= cnt_r + 12'd1;
                    end
                end
                RELEASE: begin
                    done_r    <= 3'b000;
                    timeout_r <= 1'b0;
                    grant_r   <= 3'b000;
                    busy_r    <= 1'b0;
                    last_r    <= idx_r;
                    state_r   <= IDLE;
                end
                default: begin
                    done_r    <= 3'b000;
                    timeout_r <= 1'b0;
                    grant_r   <= 3'b000;
                    start_r   <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign grant     = grant_r;
    assign done      = done_r;
    assign drawStart = start_r;
    assign drawKind  = kind_r;
    assign drawX     = x_r;
    assign drawY     = y_r;
    assign timeout   = timeout_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_draw_arbiter.sv
// Bench for draw_arbiter: directed vector table, hand-written corner
// sequences, and randomized traffic against a timeline reference model.
module tb_draw_arbiter;

    localparam int T_MAIN = 16;
    localparam int T_W    = 8;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [2:0]  kind = 3'b000;
    logic [26:0] x_in = 27'd0;
    logic [23:0] y_in = 24'd0;
    logic        drawDone = 1'b0;

    logic [2:0]  grant, done;
    logic        drawStart, drawKind, timeout, busy;
    logic [8:0]  drawX;
    logic [7:0]  drawY;

    logic [2:0]  w_grant, w_done;
    logic        w_drawStart, w_drawKind, w_timeout, w_busy;
    logic [8:0]  w_drawX;
    logic [7:0]  w_drawY;

    int total = 0;
    int bad   = 0;

    draw_arbiter #(.TIMEOUT(T_MAIN)) dut (
        .clock(clock), .resetn(resetn), .req(req), .kind(kind),
        .x_in(x_in), .y_in(y_in), .grant(grant), .done(done),
        .drawStart(drawStart), .drawKind(drawKind), .drawX(drawX),
        .drawY(drawY), .drawDone(drawDone), .timeout(timeout), .busy(busy)
    );

    draw_arbiter #(.TIMEOUT(T_W)) dut_w (
        .clock(clock), .resetn(resetn), .req(req), .kind(kind),
        .x_in(x_in), .y_in(y_in), .grant(w_grant), .done(w_done),
        .drawStart(w_drawStart), .drawKind(w_drawKind), .drawX(w_drawX),
        .drawY(w_drawY), .drawDone(drawDone), .timeout(w_timeout), .busy(w_busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset(input logic [2:0] r0);
        resetn   = 1'b0;
        req      = r0;
        kind     = 3'b000;
        x_in     = 27'd0;
        y_in     = 24'd0;
        drawDone = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [2:0]  req;
        logic [2:0]  kind;
        logic [26:0] x;
        logic [23:0] y;
        logic        dd;
        logic [2:0]  g;
        logic [2:0]  d;
        logic        st, bz, to, dk;
        logic [8:0]  dx;
        logic [7:0]  dy;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic [2:0] r, input logic [2:0] k, input logic [26:0] x,
                        input logic [23:0] y, input logic dd, input logic [2:0] g,
                        input logic [2:0] d, input logic st, input logic bz, input logic to,
                        input logic dk, input logic [8:0] dx, input logic [7:0] dy);
        vec_t v;
        v.req = r; v.kind = k; v.x = x; v.y = y; v.dd = dd;
        v.g = g; v.d = d; v.st = st; v.bz = bz; v.to = to;
        v.dk = dk; v.dx = dx; v.dy = dy;
        tbl.push_back(v);
    endtask

    task automatic run_table();
        // stray drawDone in IDLE
        addv(3'b000, 3'b000, 27'd0, 24'd0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
        // single request from requester 0
        addv(3'b001, 3'b001, {9'd0, 9'd0, 9'd95}, {8'd0, 8'd0, 8'd221}, 1'b0,
             3'b001, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 9'd95, 8'd221);
        // stray drawDone in ISSUE, inputs changed while granted
        addv(3'b001, 3'b000, {9'd0, 9'd0, 9'd300}, {8'd0, 8'd0, 8'd5}, 1'b1,
             3'b001, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 9'd95, 8'd221);
        for (int i = 0; i < 9; i++)
            addv(3'b001, 3'b000, {9'd0, 9'd0, 9'd300}, {8'd0, 8'd0, 8'd5}, 1'b0,
                 3'b001, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 9'd95, 8'd221);
        // drawer answers on the 10th WAIT cycle
        addv(3'b001, 3'b000, {9'd0, 9'd0, 9'd300}, {8'd0, 8'd0, 8'd5}, 1'b1,
             3'b001, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1, 9'd95, 8'd221);
        addv(3'b000, 3'b000, 27'd0, 24'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 9'd95, 8'd221);
        // requester 1 with x1 = 160, then x1 changed to 200 while granted
        addv(3'b010, 3'b000, {9'd0, 9'd160, 9'd0}, {8'd0, 8'd17, 8'd0}, 1'b0,
             3'b010, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 9'd160, 8'd17);
        for (int i = 0; i < 4; i++)
            addv(3'b010, 3'b010, {9'd0, 9'd200, 9'd0}, {8'd0, 8'd99, 8'd0}, 1'b0,
                 3'b010, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 9'd160, 8'd17);
        addv(3'b010, 3'b010, {9'd0, 9'd200, 9'd0}, {8'd0, 8'd99, 8'd0}, 1'b1,
             3'b010, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 9'd160, 8'd17);
        addv(3'b000, 3'b000, {9'd0, 9'd200, 9'd0}, 24'd0, 1'b0,
             3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 9'd160, 8'd17);

        do_reset(3'b000);
        check("reset_state", {grant, done, drawStart, busy, timeout, drawKind, drawX, drawY}, 64'd0);
        foreach (tbl[i]) begin
            req      = tbl[i].req;
            kind     = tbl[i].kind;
            x_in     = tbl[i].x;
            y_in     = tbl[i].y;
            drawDone = tbl[i].dd;
            @(posedge clock);
            @(negedge clock);
            check($sformatf("vec%0d", i),
                  {grant, done, drawStart, busy, timeout, drawKind, drawX, drawY},
                  {tbl[i].g, tbl[i].d, tbl[i].st, tbl[i].bz, tbl[i].to, tbl[i].dk, tbl[i].dx, tbl[i].dy});
        end
    endtask

    // ---------------- hand-written sequences ----------------
    // Wait for a grant on the main instance, answer after dly cycles, drop req.
    task automatic serve(input logic [2:0] eg, input int dly, input string nm);
        int n = 0;
        while (grant == 3'b000 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check({nm, "_grant"}, grant, eg);
        check({nm, "_start"}, drawStart, 1'b1);
        repeat (dly) @(negedge clock);
        drawDone = 1'b1;
        @(negedge clock);
        drawDone = 1'b0;
        check({nm, "_done"}, {done, timeout}, {eg, 1'b0});
        req = req & ~eg;
        @(negedge clock);
        check({nm, "_idle"}, {grant, busy}, 4'd0);
    endtask

    task automatic run_fairness();
        do_reset(3'b111);
        serve(3'b001, 5, "fair0");
        serve(3'b010, 5, "fair1");
        serve(3'b100, 5, "fair2");
        req = 3'b101;
        serve(3'b001, 5, "fair3");
        serve(3'b100, 5, "fair4");
    endtask

    task automatic run_watchdog();
        int n = 0;
        do_reset(3'b000);
        req  = 3'b010;
        kind = 3'b010;
        x_in = {9'd0, 9'd123, 9'd0};
        y_in = {8'd0, 8'd45, 8'd0};
        while (w_grant == 3'b000 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("wd_grant", {w_grant, w_drawStart, w_drawKind, w_drawX, w_drawY},
              {3'b010, 1'b1, 1'b1, 9'd123, 8'd45});
        for (int i = 1; i <= T_W; i++) begin
            @(negedge clock);
            check($sformatf("wd_quiet%0d", i), {w_done, w_timeout}, 4'd0);
        end
        @(negedge clock);
        check("wd_fire", {w_done, w_timeout}, {3'b010, 1'b1});
        req = 3'b000;
        @(negedge clock);
        check("wd_after", {w_done, w_timeout, w_busy, w_grant}, 8'd0);
        req = 3'b001;
        n = 0;
        while (w_grant == 3'b000 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("wd_next_grant", w_grant, 3'b001);
        repeat (2) @(negedge clock);
        drawDone = 1'b1;
        @(negedge clock);
        drawDone = 1'b0;
        check("wd_next_done", {w_done, w_timeout}, {3'b001, 1'b0});
        req = 3'b000;
        @(negedge clock);
    endtask

    task automatic run_reset_mid_wait();
        int n = 0;
        do_reset(3'b000);
        req = 3'b001;
        while (grant == 3'b000 && n < 40) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        check("rst_pre_busy", busy, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_async", {grant, done, drawStart, busy}, 8'd0);
        req = 3'b111;
        @(negedge clock);
        check("rst_held", {grant, done, drawStart, busy, timeout}, 9'd0);
        resetn = 1'b1;
        serve(3'b001, 3, "rst_first");
        req = 3'b000;
        @(negedge clock);
    endtask

    // ---------------- randomized traffic vs timeline model ----------------
    initial begin
        run_table();
        run_fairness();
        run_watchdog();
        run_reset_mid_wait();
        run_random_main(3000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic run_random_main(input int ncyc);
        int         last = 2;
        int         owner = -1;
        int         g = 0;
        int         r = 0;
        int         free_e = 0;
        bit         resolved = 1'b0;
        bit         to_f = 1'b0;
        logic       lk = 1'b0;
        logic [8:0] lx = 9'd0;
        logic [7:0] ly = 8'd0;
        logic [2:0] eg, ed, prev_ed;
        logic       est, eto, ebz;

        prev_ed = 3'b000;
        do_reset(3'b000);
        for (int e = 0; e < ncyc; e++) begin
            // requesters hold req until their done, drop it right after
            for (int b = 0; b < 3; b++) begin
                if (prev_ed[b])
                    req[b] = 1'b0;
                else if (!req[b] && $urandom_range(3) == 0)
                    req[b] = 1'b1;
                else
                    req[b] = req[b];
            end
            kind     = 3'($urandom);
            x_in     = {9'($urandom_range(319)), 9'($urandom_range(319)), 9'($urandom_range(319))};
            y_in     = {8'($urandom_range(239)), 8'($urandom_range(239)), 8'($urandom_range(239))};
            drawDone = ($urandom_range(5) == 0);
            @(posedge clock);

            // first drawDone seen after the start pulse, or T_MAIN silent cycles
            if (owner >= 0 && !resolved && e >= g + 2) begin
                if (drawDone) begin
                    resolved = 1'b1; r = e; to_f = 1'b0;
                end else if (e - g - 1 == T_MAIN) begin
                    resolved = 1'b1; r = e; to_f = 1'b1;
                end
            end else if (owner >= 0 && resolved && e == r + 1) begin
                last   = owner;
                owner  = -1;
                free_e = e + 1;
            end
            if (owner < 0 && e >= free_e && req != 3'b000) begin
                for (int k = 1; k <= 3 && owner < 0; k++)
                    if (req[(last + k) % 3]) owner = (last + k) % 3;
                g        = e;
                resolved = 1'b0;
                lk       = kind[owner];
                lx       = x_in[owner*9 +: 9];
                ly       = y_in[owner*8 +: 8];
            end
            eg  = (owner >= 0) ? 3'(1 << owner) : 3'b000;
            ebz = (owner >= 0);
            est = (owner >= 0) && (e == g);
            ed  = (owner >= 0 && resolved && e == r) ? eg : 3'b000;
            eto = (owner >= 0 && resolved && e == r) ? to_f : 1'b0;
            prev_ed = ed;

            @(negedge clock);
            check($sformatf("rand_cyc%0d", e),
                  {grant, done, drawStart, busy, timeout, drawKind, drawX, drawY},
                  {eg, ed, est, ebz, eto, lk, lx, ly});
        end
        req      = 3'b000;
        drawDone = 1'b0;
    endtask

endmodule

// File: doc/draw_arbiter.md
# draw_arbiter

Round-robin arbiter that shares the single sprite drawer (the VGA write path) among three requesters: the character movement FSM, the moving-platform animator and the button animator. Each requester holds a level request, a draw kind and a coordinate. The arbiter grants one requester at a time, latches its command, issues a start pulse to the drawer and waits for the drawer's done pulse. It then returns a one-cycle done pulse to the granted requester. A watchdog releases the grant if the drawer never answers.

## Interface
Parameters:
- TIMEOUT, default 4095: maximum WAIT cycles before forced release; legal range 1..4095 (12-bit counter).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  3  level request per requester (bit 0 char FSM, 1 platform, 2 button); held high until that requester's done pulse.
- kind  in  3  per requester: 0 = redraw background patch, 1 = draw character/object sprite.
- x_in  in  27  {x2,x1,x0}, 9 bits each, top-left X (0..319).
- y_in  in  24  {y2,y1,y0}, 8 bits each, top-left Y (0..239).
- grant  out  3  one-hot, the requester currently owning the drawer; 0 when idle.
- done  out  3  one-cycle pulse to the granted requester when its draw is finished or timed out.
- drawStart  out  1  one-cycle start pulse to the sprite drawer.
- drawKind  out  1  latched kind of the granted command.
- drawX  out  9  latched X of the granted command.
- drawY  out  8  latched Y of the granted command.
- drawDone  in  1  completion pulse from the sprite drawer.
- timeout  out  1  one-cycle error pulse, coincident with done, when the watchdog fired.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RELEASE.
- IDLE: if req != 0, select the winner by round-robin.
  - Search order is last+1, last+2, last+3 (mod 3), where last is the index of the most recently released requester.
  - Latch winner index, kind, x, y into drawKind/drawX/drawY; set grant one-hot; go to ISSUE.
  - If req == 0, stay in IDLE.
- ISSUE: drawStart = 1 for this cycle only; clear the watchdog counter; go to WAIT.
- WAIT:
  - drawDone = 1: go to RELEASE, timeout flag cleared.
  - Otherwise, counter == TIMEOUT-1: go to RELEASE with the timeout flag set.
  - Otherwise: increment the counter.
- RELEASE:
  - done[idx] = 1 for one cycle; timeout = flag.
  - last <= idx; grant cleared at the exit edge; go to IDLE.
- drawKind/drawX/drawY stay stable from the grant edge until the next grant. Changes on x_in/y_in/kind while granted have no effect.
- drawDone is ignored in IDLE, ISSUE and RELEASE.
- A requester must deassert req in the cycle after its done pulse. If req is still high in IDLE, it is treated as a new request, but lower round-robin priority applies.
- Reset values: state IDLE, last = 2 (requester 0 has first priority), counter 0, grant 0, done 0, drawStart 0, drawKind 0, drawX 0, drawY 0, timeout 0, busy 0.
- Reset asserted mid-operation: everything returns to reset values immediately; no done pulse is generated. The drawer and requesters share resetn.

## Timing
- The req edge sampled in IDLE at edge k produces: grant and latched command at k; drawStart high during cycle k..k+1 (ISSUE).
- drawDone sampled at edge m in WAIT produces: done and RELEASE during m..m+1; grant = 0 and IDLE from m+1.
- The earliest next grant is edge m+2. A back-to-back service cycle is 4 clocks plus drawer time.
- Timeout: with no drawDone, done/timeout assert exactly TIMEOUT cycles after the first WAIT cycle.
- All outputs are registered or decoded from state only (Moore); there are no combinational paths from req or drawDone to outputs.

## Test plan
- Single request:
  - Stimulus: req=001, kind0=1, x0=95, y0=221; drawDone pulsed on the 10th WAIT cycle.
  - Required: grant=001 one edge after req; drawStart pulse once with drawX=95, drawY=221, drawKind=1; done=001 one cycle after drawDone; busy low afterwards.
- Fairness:
  - Stimulus: req=111 held from reset, each requester drops req after its done; drawer answers in 5 cycles.
  - Required: grant order 001, 010, 100; then with req=101 re-raised, order 001, 100.
- Watchdog:
  - Stimulus: TIMEOUT=8, req=010, drawDone never asserted.
  - Required: done=010 and timeout=1 on the same cycle, 8 cycles after WAIT entry; next IDLE grant proceeds normally.
- Latch stability:
  - Stimulus: change x1 from 160 to 200 during WAIT.
  - Required: drawX stays 160 until RELEASE.
- Stray done:
  - Stimulus: drawDone pulses while in IDLE and while in ISSUE.
  - Required: no done, no state change beyond the normal ISSUE→WAIT transition.
- Reset mid-WAIT:
  - Stimulus: resetn low during WAIT.
  - Required: grant, done, drawStart and busy go to 0 asynchronously; after release, req=111 is granted to requester 0 first.
